bool_lut_unit: RTL
==================

Name: bool_lut_unit

Overview:
- Multi-channel programmable Boolean function unit, registered.
- Each of CH channels evaluates an arbitrary N_IN-input function from a 2^N_IN-bit truth table.
- Truth tables reload at run time through a serial configuration port, one channel at a time.
- Generalises the fixed 3-input function d=(~a&~b)|~c. The reset table 8'h57 reproduces that function on every channel.

Parameters:
- N_IN, 3, inputs per channel (1..6).
- CH, 2, number of channels (1..8).
- DEFAULT_TT, 8'h57, reset truth table for every channel (width 2^N_IN). Bit i = f(index i), index = {in[N_IN-1],...,in[0]}.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  evaluate in_data this cycle
- in_data  in  CH*N_IN  channel k inputs at [k*N_IN +: N_IN]
- out_valid  out  1  out_data valid
- out_data  out  CH  bit k = result of channel k
- cfg_start  in  1  pulse: begin a table load
- cfg_ch  in  max(1,clog2(CH))  target channel, sampled on cfg_start
- cfg_en  in  1  shift-enable for cfg_bit
- cfg_bit  in  1  serial table bit, MSB (index 2^N_IN-1) first
- cfg_busy  out  1  high in LOAD and COMMIT
- cfg_done  out  1  one-cycle pulse: new table in effect
- cfg_err  out  1  one-cycle pulse: load discarded (bad channel)

Behaviour:
- Reset (async): all tables = DEFAULT_TT, state IDLE, bit counter 0, shadow 0. out_valid, out_data, cfg_done, cfg_err all 0.
- Evaluation: latency 1.
  - Edge with in_valid=1 registers out_data[k] = table_k[in_data slice k] and out_valid=1.
  - Edge with in_valid=0 registers out_valid=0; out_data holds its last value.
  - Back-to-back in_valid gives one result per cycle. No backpressure.
- Config FSM, states IDLE, LOAD, COMMIT:
  - IDLE: cfg_start=1 → LOAD. Latches cfg_ch, clears the counter. cfg_en is ignored in IDLE.
  - LOAD: each cycle with cfg_en=1 shifts cfg_bit into the shadow LSB (shadow <= {shadow, cfg_bit}) and increments the counter. cfg_en=0 holds state.
  - LOAD: when the 2^N_IN-th bit is accepted → COMMIT.
  - LOAD: cfg_start=1 restarts the load. Counter cleared, cfg_ch re-latched, the cfg_en bit in that same cycle is dropped, the partial table is discarded.
  - COMMIT (exactly 1 cycle): at the edge ending COMMIT, if the latched ch < CH then table[ch] <= shadow and cfg_done <= 1; otherwise cfg_err <= 1 and no table changes. Next state IDLE.
  - COMMIT: cfg_start is ignored.
- cfg_done and cfg_err are registered. Each is high for exactly the one cycle after COMMIT.
- Simultaneous events:
  - in_valid sampled at the commit edge uses the OLD table.
  - in_valid in the cfg_done-high cycle uses the NEW table.
  - Other channels are never disturbed by a load.
- Reset mid-load aborts the load: the partial table is lost and tables revert to DEFAULT_TT.
- The counter is clog2(2^N_IN)+1 bits wide. No wrap in LOAD, because reaching 2^N_IN forces COMMIT.

Test Plan:
1. Reset, then in_valid with ch0 inputs 000, 001, 011, 101 → out_data[0] = 1, 1, 0, 0 one cycle later, out_valid=1 each cycle. ch1 gives the same results for the same inputs.
2. Load AND into ch1:
   - Stimulus: cfg_start with cfg_ch=1, then 8 cfg_en cycles carrying bits 1,0,0,0,0,0,0,0 (8'h80).
   - Response: cfg_busy high for 9 cycles, then cfg_done pulse.
   - Check: ch1 input 111 → 1, 110 → 0. ch0 input 011 → 0 (unchanged).
3. Abort and stall:
   - Stimulus: load ch0, 4 bits, cfg_start again, then 8'hFF with cfg_en gaps inserted.
   - Response: single cfg_done.
   - Check: ch0 = 1 for all 8 inputs.
4. Commit/eval collision: in_valid asserted at the commit edge and again in the cfg_done cycle → first result from the old table, second from the new table.
5. With CH=3, load cfg_ch=3 → cfg_err pulse, no cfg_done, all tables unchanged.
6. Assert rst after 5 bits of a load → cfg_busy=0, all tables = 8'h57, outputs 0. A following full load succeeds.

Source files
------------

// File: rtl/bool_lut_unit.sv
// bool_lut_unit: CH-channel registered N_IN-input truth-table evaluator
// with a serial per-channel table loader (IDLE -> LOAD -> COMMIT).
module bool_lut_unit #(
  parameter int N_IN = 3,
  parameter int CH = 2,
  parameter logic [(2**N_IN)-1:0] DEFAULT_TT = 'h57,
  localparam int TT = 2**N_IN,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1,
  localparam int NW = $clog2(TT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CH*N_IN-1:0] in_data,
  output logic             out_valid,
  output logic [CH-1:0]    out_data,
  input  logic             cfg_start,
  input  logic [CW-1:0]    cfg_ch,
  input  logic             cfg_en,
  input  logic             cfg_bit,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t r_st, w_nst;
  logic [TT-1:0] r_tt [CH];
  logic [TT-1:0] r_sh;
  logic [NW-1:0] r_cnt;
  logic [CW-1:0] r_ch;
  logic w_last, w_ok;
  assign w_last = cfg_en && r_cnt == NW'(TT - 1);
  assign w_ok = int'(r_ch) < CH;
  assign cfg_busy = r_st != IDLE;
  always_comb begin
    w_nst = r_st;
    w_nst = (r_st == IDLE) ? (cfg_start ? LOAD : IDLE) :
            (r_st == LOAD) ? (cfg_start ? LOAD : (w_last ? COMMIT : LOAD)) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_st <= IDLE;
    else r_st <= w_nst;
  // A restart in LOAD wins over a shift in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sh <= '0;
      r_ch <= '0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      for (int k = 0; k < CH; k++) r_tt[k] <= DEFAULT_TT;
    end else begin
      cfg_done <= r_st == COMMIT && w_ok;
      cfg_err <= r_st == COMMIT && !w_ok;
      if (cfg_start && r_st != COMMIT) begin
        r_ch <= cfg_ch;
        r_cnt <= '0;
      end else if (r_st == LOAD && cfg_en) begin
        r_sh <= {r_sh[TT-2:0], cfg_bit};
        r_cnt <= r_cnt + 1'b1;
      end
      for (int k = 0; k < CH; k++)
        if (r_st == COMMIT && r_ch == CW'(k)) r_tt[k] <= r_sh;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        for (int k = 0; k < CH; k++) out_data[k] <= r_tt[k][in_data[k*N_IN +: N_IN]];
    end
  end
endmodule
